// File: rtl/load_store_unit.sv
// Load/store sequencer for the byte-addressed data memory port.
// Byte/half stores are done as read-modify-write since the memory always writes a full word.
module load_store_unit #(
   parameter int MEM_BYTES    = 32,
   parameter bit STRICT_ALIGN = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_signed_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   output logic        mem_read_o,
   output logic        mem_write_o,
   input  logic [31:0] mem_data_i
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_STORE, S_RMW_RD, S_RMW_WR, S_DONE
   } state_t;

   localparam logic [1:0]  SZ_BYTE = 2'b00;
   localparam logic [1:0]  SZ_HALF = 2'b01;
   localparam logic [1:0]  SZ_WORD = 2'b10;
   localparam logic [32:0] LIMIT   = 33'(MEM_BYTES);

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] result_q, result_d;
   logic        err_q, err_d;

   logic [32:0] end_addr;
   logic        oob, misalign, fault;

   // 33-bit sum so an address near 2^32 cannot wrap into range
   always_comb begin
      end_addr = {1'b0, req_addr_i} + 33'd3;
      oob      = (end_addr >= LIMIT);
      misalign = STRICT_ALIGN &&
                 (((req_size_i == SZ_HALF) && req_addr_i[0]) ||
                  ((req_size_i == SZ_WORD) && (req_addr_i[1:0] != 2'b00)));
      fault    = (req_size_i == 2'b11) || oob || misalign;
   end

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      size_d       = size_q;
      signed_d     = signed_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      result_d     = result_q;
      err_d        = err_q;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      resp_rdata_o = '0;
      resp_err_o   = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               we_d     = req_we_i;
               size_d   = req_size_i;
               signed_d = req_signed_i;
               addr_d   = req_addr_i;
               wdata_d  = req_wdata_i;
               result_d = '0;
               err_d    = 1'b0;
               if (fault) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else if (!req_we_i) begin
                  state_d = S_LOAD;
               end else if (req_size_i == SZ_WORD) begin
                  state_d = S_STORE;
               end else begin
                  state_d = S_RMW_RD;
               end
            end
         end
         S_LOAD: begin
            mem_read_o = 1'b1;
            mem_addr_o = addr_q;
            case (size_q)
               SZ_BYTE: result_d = {{24{signed_q & mem_data_i[7]}}, mem_data_i[7:0]};
               SZ_HALF: result_d = {{16{signed_q & mem_data_i[15]}}, mem_data_i[15:0]};
               default: result_d = mem_data_i;
            endcase
            state_d = S_DONE;
         end
         S_STORE: begin
            mem_write_o = 1'b1;
            mem_addr_o  = addr_q;
            mem_data_o  = wdata_q;
            state_d     = S_DONE;
         end
         S_RMW_RD: begin
            mem_read_o = 1'b1;
            mem_addr_o = addr_q;
            // merged word overwrites the latched store data; result stays 0 for stores
            if (size_q == SZ_BYTE) wdata_d = {mem_data_i[31:8], wdata_q[7:0]};
            else                   wdata_d = {mem_data_i[31:16], wdata_q[15:0]};
            state_d = S_RMW_WR;
         end
         S_RMW_WR: begin
            mem_write_o = 1'b1;
            mem_addr_o  = addr_q;
            mem_data_o  = wdata_q;
            state_d     = S_DONE;
         end
         S_DONE: begin
            resp_valid_o = 1'b1;
            resp_rdata_o = result_q;
            resp_err_o   = err_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         size_q   <= 2'b00;
         signed_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

endmodule
